// File: rtl/cram_access_arbiter.sv
// rtl/cram_access_arbiter.sv - shares one CRAM command port among NUM_REQ requesters
// Serialises one transaction at a time: IDLE (arbitrate) -> ISSUE -> WAIT (ack or timeout) -> RESP.
module cram_access_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int ADDR_WIDTH     = 22,
    parameter int DATA_WIDTH     = 16,
    parameter int RR_MODE        = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic                          rsp_error,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          mem_req,
    output logic                          mem_write,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic                          mem_ack,
    input  logic [DATA_WIDTH-1:0]         mem_rdata,
    output logic                          busy
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] LAST_IDX = GW'(NUM_REQ - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                r_state;
    state_t                w_next;
    logic [GW-1:0]         r_grant;
    logic [GW-1:0]         r_last_grant;
    logic                  r_write;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_error;
    logic [CW-1:0]         r_cnt;

    logic [GW-1:0]         w_win;
    logic [GW-1:0]         w_sel;
    logic                  w_found;

    // Round-robin starts one past the previous winner; fixed mode always starts at 0.
    always_comb begin
        w_win   = '0;
        w_sel   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (RR_MODE != 0) begin
                w_sel = GW'((int'(r_last_grant) + 1 + k) % NUM_REQ);
            end else begin
                w_sel = GW'(k);
            end
            if (!w_found && req_valid[w_sel]) begin
                w_found = 1'b1;
                w_win   = w_sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = '0;
        rsp_valid = '0;
        mem_req   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found && !reset) begin
                    req_ready[w_win] = 1'b1;
                    w_next           = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_req = !reset;
                w_next  = S_WAIT;
            end
            S_WAIT: begin
                if (mem_ack || (r_cnt == CNT_LAST)) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid[r_grant] = 1'b1;
                w_next             = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant      <= '0;
            r_last_grant <= LAST_IDX;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rsp_data   <= '0;
            r_rsp_error  <= 1'b0;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_write      <= req_write[w_win];
                        r_addr       <= req_addr[w_win*ADDR_WIDTH +: ADDR_WIDTH];
                        r_wdata      <= req_wdata[w_win*DATA_WIDTH +: DATA_WIDTH];
                        r_grant      <= w_win;
                        r_last_grant <= w_win;
                    end
                end
                S_ISSUE: r_cnt <= '0;
                S_WAIT: begin
                    // An ack on the last counted cycle still completes normally.
                    if (mem_ack) begin
                        r_rsp_data  <= r_write ? '0 : mem_rdata;
                        r_rsp_error <= 1'b0;
                    end else if (r_cnt == CNT_LAST) begin
                        r_rsp_data  <= '0;
                        r_rsp_error <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_write = r_write;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign rsp_data  = r_rsp_data;
    assign rsp_error = r_rsp_error;
    assign busy      = (r_state != S_IDLE);
endmodule

// File: tb/tb_cram_access_arbiter.sv
// tb/tb_cram_access_arbiter.sv - scoreboard bench for cram_access_arbiter
// Instance a: round-robin, timeout 8; instance b: fixed priority with an always-fast controller.
module tb_cram_access_arbiter;
    logic clk;
    int   cyc;
    int   n_cmp;
    int   n_bad;

    typedef struct packed {
        logic [2:0]  idx;
        logic [15:0] data;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    logic        a_reset;
    logic [2:0]  a_req_valid, a_req_write, a_req_ready, a_rsp_valid;
    logic [65:0] a_req_addr;
    logic [47:0] a_req_wdata;
    logic        a_rsp_error, a_mem_req, a_mem_write, a_mem_ack, a_busy;
    logic [15:0] a_rsp_data, a_mem_wdata, a_mem_rdata;
    logic [21:0] a_mem_addr;
    logic        a_ack_en;
    int          a_ack_dly;
    logic [15:0] a_rdata;

    logic        b_reset;
    logic [2:0]  b_req_valid, b_req_write, b_req_ready, b_rsp_valid;
    logic [65:0] b_req_addr;
    logic [47:0] b_req_wdata;
    logic        b_rsp_error, b_mem_req, b_mem_write, b_mem_ack, b_busy;
    logic [15:0] b_rsp_data, b_mem_wdata, b_mem_rdata;
    logic [21:0] b_mem_addr;

    cram_access_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(22), .DATA_WIDTH(16), .RR_MODE(1), .TIMEOUT_CYCLES(8)) u_a (
        .clk(clk), .reset(a_reset), .req_valid(a_req_valid), .req_write(a_req_write),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_ready(a_req_ready),
        .rsp_valid(a_rsp_valid), .rsp_error(a_rsp_error), .rsp_data(a_rsp_data),
        .mem_req(a_mem_req), .mem_write(a_mem_write), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_ack(a_mem_ack), .mem_rdata(a_mem_rdata), .busy(a_busy)
    );

    cram_access_arbiter #(.NUM_REQ(3), .ADDR_WIDTH(22), .DATA_WIDTH(16), .RR_MODE(0), .TIMEOUT_CYCLES(8)) u_b (
        .clk(clk), .reset(b_reset), .req_valid(b_req_valid), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_ready(b_req_ready),
        .rsp_valid(b_rsp_valid), .rsp_error(b_rsp_error), .rsp_data(b_rsp_data),
        .mem_req(b_mem_req), .mem_write(b_mem_write), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_ack(b_mem_ack), .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Controller model a: ack a_ack_dly cycles after the first WAIT cycle.
    always begin
        @(negedge clk);
        if (a_mem_req === 1'b1 && a_ack_en) begin
            repeat (a_ack_dly) @(negedge clk);
            @(posedge clk);
            #1;
            a_mem_rdata = a_rdata;
            a_mem_ack   = 1'b1;
            @(posedge clk);
            #1;
            a_mem_ack = 1'b0;
        end
    end

    always begin
        @(negedge clk);
        if (b_mem_req === 1'b1) begin
            @(posedge clk);
            #1;
            b_mem_ack = 1'b1;
            @(posedge clk);
            #1;
            b_mem_ack = 1'b0;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_a_ready(input int lim);
        for (int n = 0; n < lim; n++) begin
            @(negedge clk);
            if (a_req_ready != 3'b000) break;
        end
    endtask

    task automatic wait_a_rsp(input int lim);
        for (int n = 0; n < lim; n++) begin
            @(negedge clk);
            if (a_rsp_valid != 3'b000) break;
        end
    endtask

    task automatic wait_b_ready(input int lim);
        for (int n = 0; n < lim; n++) begin
            @(negedge clk);
            if (b_req_ready != 3'b000) break;
        end
    endtask

    task automatic wait_b_rsp(input int lim);
        for (int n = 0; n < lim; n++) begin
            @(negedge clk);
            if (b_rsp_valid != 3'b000) break;
        end
    endtask

    task automatic test_reset;
        a_reset = 1'b1; b_reset = 1'b1;
        a_req_valid = '0; a_req_write = '0; a_req_addr = '0; a_req_wdata = '0;
        b_req_valid = '0; b_req_write = '0; b_req_addr = '0; b_req_wdata = '0;
        a_mem_ack = 1'b0; a_mem_rdata = '0; b_mem_ack = 1'b0; b_mem_rdata = 16'h00B0;
        a_ack_en = 1'b0; a_ack_dly = 0; a_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({a_req_ready, a_rsp_valid, a_rsp_error, a_rsp_data, a_mem_req, a_mem_write,
             a_mem_addr, a_mem_wdata, a_busy} !== 64'd0) begin
            n_bad++;
            $display("FAIL reset_a: outputs got %h want 0", {a_req_ready, a_rsp_valid, a_rsp_error,
                     a_rsp_data, a_mem_req, a_mem_write, a_mem_addr, a_mem_wdata, a_busy});
        end
        n_cmp++;
        if ({b_req_ready, b_rsp_valid, b_rsp_error, b_rsp_data, b_mem_req, b_mem_write,
             b_mem_addr, b_mem_wdata, b_busy} !== 64'd0) begin
            n_bad++;
            $display("FAIL reset_b: outputs got %h want 0", {b_req_ready, b_rsp_valid, b_rsp_error,
                     b_rsp_data, b_mem_req, b_mem_write, b_mem_addr, b_mem_wdata, b_busy});
        end
        @(posedge clk);
        #1;
        a_reset = 1'b0; b_reset = 1'b0;
    endtask

    task automatic test_single_read;
        int   t0;
        exp_t e;
        a_ack_en = 1'b1; a_ack_dly = 1; a_rdata = 16'hBEEF;
        @(posedge clk);
        #1;
        a_req_addr[0 +: 22] = 22'h00123; a_req_write = 3'b000; a_req_valid = 3'b001;
        wait_a_ready(10);
        t0 = cyc;
        n_cmp++;
        if (a_req_ready !== 3'b001) begin
            n_bad++; $display("FAIL single_ready: got %b want 001", a_req_ready);
        end
        exp_q.push_back({3'b001, 16'hBEEF, 1'b0});
        @(posedge clk);
        #1;
        a_req_valid = 3'b000;
        @(negedge clk);
        n_cmp++;
        if ({a_mem_req, a_mem_write, a_mem_addr} !== {1'b1, 1'b0, 22'h00123}) begin
            n_bad++;
            $display("FAIL single_issue: req/wr/addr got %b/%b/%h want 1/0/000123", a_mem_req, a_mem_write, a_mem_addr);
        end
        wait_a_rsp(20);
        n_cmp++;
        if (cyc - t0 != 4) begin
            n_bad++; $display("FAIL single_latency: got %0d want 4", cyc - t0);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if ({a_rsp_valid, a_rsp_data, a_rsp_error} !== {e.idx, e.data, e.err}) begin
            n_bad++;
            $display("FAIL single_rsp: got %b/%h/%b want %b/%h/%b", a_rsp_valid, a_rsp_data, a_rsp_error, e.idx, e.data, e.err);
        end
    endtask

    task automatic test_rr_fairness;
        int         t_prev;
        int         w;
        logic [2:0] oh;
        exp_t       e;
        a_reset = 1'b1;
        @(posedge clk);
        #1;
        a_reset = 1'b0;
        a_ack_en = 1'b1; a_ack_dly = 0; a_rdata = 16'h5555;
        a_req_addr = {22'h000102, 22'h000101, 22'h000100};
        a_req_wdata = {16'hC002, 16'hC001, 16'hC000};
        a_req_write = 3'b010;
        a_req_valid = 3'b111;
        t_prev = 0;
        for (int g = 0; g < 6; g++) begin
            wait_a_ready(10);
            w  = g % 3;
            oh = 3'b001 << w;
            n_cmp++;
            if (a_req_ready !== oh) begin
                n_bad++; $display("FAIL rr_grant%0d: got %b want %b", g, a_req_ready, oh);
            end
            if (g > 0) begin
                n_cmp++;
                if (cyc - t_prev != 4) begin
                    n_bad++; $display("FAIL rr_spacing%0d: got %0d want 4", g, cyc - t_prev);
                end
            end
            t_prev = cyc;
            exp_q.push_back({oh, (w == 1) ? 16'h0000 : 16'h5555, 1'b0});
            if (g == 5) begin
                @(posedge clk);
                #1;
                a_req_valid = 3'b000;
            end
            wait_a_rsp(10);
            e = exp_q.pop_front();
            n_cmp++;
            if ({a_rsp_valid, a_rsp_data, a_rsp_error} !== {e.idx, e.data, e.err}) begin
                n_bad++;
                $display("FAIL rr_rsp%0d: got %b/%h/%b want %b/%h/%b", g, a_rsp_valid, a_rsp_data, a_rsp_error, e.idx, e.data, e.err);
            end
        end
    endtask

    task automatic test_timeout;
        int   t0;
        exp_t e;
        a_ack_en = 1'b0;
        @(posedge clk);
        #1;
        a_req_addr[22 +: 22] = 22'h0002AA; a_req_wdata[16 +: 16] = 16'h7777;
        a_req_write = 3'b010; a_req_valid = 3'b010;
        wait_a_ready(10);
        t0 = cyc;
        exp_q.push_back({3'b010, 16'h0000, 1'b1});
        @(posedge clk);
        #1;
        a_req_valid = 3'b000;
        wait_a_rsp(30);
        n_cmp++;
        if (cyc - t0 != 10) begin
            n_bad++; $display("FAIL timeout_latency: got %0d want 10", cyc - t0);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if ({a_rsp_valid, a_rsp_data, a_rsp_error} !== {e.idx, e.data, e.err}) begin
            n_bad++;
            $display("FAIL timeout_rsp: got %b/%h/%b want %b/%h/%b", a_rsp_valid, a_rsp_data, a_rsp_error, e.idx, e.data, e.err);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        a_mem_rdata = 16'hDEAD; a_mem_ack = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({a_busy, a_rsp_valid} !== 4'b0000) begin
            n_bad++; $display("FAIL late_ack_busy: busy/rsp_valid got %b/%b want 0/000", a_busy, a_rsp_valid);
        end
        @(posedge clk);
        #1;
        a_mem_ack = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({a_busy, a_rsp_valid, a_rsp_error, a_rsp_data} !== {1'b0, 3'b000, 1'b1, 16'h0000}) begin
            n_bad++;
            $display("FAIL late_ack_hold: busy/valid/err/data got %b/%b/%b/%h want 0/000/1/0000", a_busy, a_rsp_valid, a_rsp_error, a_rsp_data);
        end
    endtask

    task automatic test_ack_final;
        int   t0;
        exp_t e;
        a_ack_en = 1'b1; a_ack_dly = 7; a_rdata = 16'h1234;
        @(posedge clk);
        #1;
        a_req_addr[0 +: 22] = 22'h00003C; a_req_write = 3'b000; a_req_valid = 3'b001;
        wait_a_ready(10);
        t0 = cyc;
        exp_q.push_back({3'b001, 16'h1234, 1'b0});
        @(posedge clk);
        #1;
        a_req_valid = 3'b000;
        wait_a_rsp(30);
        n_cmp++;
        if (cyc - t0 != 10) begin
            n_bad++; $display("FAIL final_ack_latency: got %0d want 10", cyc - t0);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if ({a_rsp_valid, a_rsp_data, a_rsp_error} !== {e.idx, e.data, e.err}) begin
            n_bad++;
            $display("FAIL final_ack_rsp: got %b/%h/%b want %b/%h/%b", a_rsp_valid, a_rsp_data, a_rsp_error, e.idx, e.data, e.err);
        end
    endtask

    task automatic test_reset_wait;
        logic [2:0] seen;
        exp_t       e;
        a_ack_en = 1'b0;
        @(posedge clk);
        #1;
        a_req_addr[0 +: 22] = 22'h000055; a_req_write = 3'b000; a_req_valid = 3'b001;
        wait_a_ready(10);
        @(posedge clk);
        #1;
        a_req_valid = 3'b000;
        @(posedge clk);
        #1;
        a_reset = 1'b1;
        @(posedge clk);
        #1;
        a_reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({a_req_ready, a_rsp_valid, a_rsp_error, a_rsp_data, a_mem_req, a_mem_write,
             a_mem_addr, a_mem_wdata, a_busy} !== 64'd0) begin
            n_bad++; $display("FAIL reset_wait_outputs: got %h want 0", {a_req_ready, a_rsp_valid, a_rsp_error,
                     a_rsp_data, a_mem_req, a_mem_write, a_mem_addr, a_mem_wdata, a_busy});
        end
        seen = 3'b000;
        repeat (6) begin
            @(negedge clk);
            seen = seen | a_rsp_valid;
        end
        n_cmp++;
        if (seen !== 3'b000) begin
            n_bad++; $display("FAIL reset_wait_no_rsp: got %b want 000", seen);
        end
        a_ack_en = 1'b1; a_ack_dly = 0; a_rdata = 16'h0A0A;
        @(posedge clk);
        #1;
        a_req_addr[44 +: 22] = 22'h000077; a_req_valid = 3'b100;
        wait_a_ready(10);
        n_cmp++;
        if (a_req_ready !== 3'b100) begin
            n_bad++; $display("FAIL post_reset_grant2: got %b want 100", a_req_ready);
        end
        exp_q.push_back({3'b100, 16'h0A0A, 1'b0});
        @(posedge clk);
        #1;
        a_req_valid = 3'b000;
        wait_a_rsp(10);
        e = exp_q.pop_front();
        n_cmp++;
        if ({a_rsp_valid, a_rsp_data, a_rsp_error} !== {e.idx, e.data, e.err}) begin
            n_bad++;
            $display("FAIL post_reset_rsp2: got %b/%h/%b want %b/%h/%b", a_rsp_valid, a_rsp_data, a_rsp_error, e.idx, e.data, e.err);
        end
        @(posedge clk);
        #1;
        a_req_valid = 3'b101;
        wait_a_ready(10);
        n_cmp++;
        if (a_req_ready !== 3'b001) begin
            n_bad++; $display("FAIL post_reset_grant0: got %b want 001", a_req_ready);
        end
        exp_q.push_back({3'b001, 16'h0A0A, 1'b0});
        @(posedge clk);
        #1;
        a_req_valid = 3'b000;
        wait_a_rsp(10);
        e = exp_q.pop_front();
        n_cmp++;
        if ({a_rsp_valid, a_rsp_data, a_rsp_error} !== {e.idx, e.data, e.err}) begin
            n_bad++;
            $display("FAIL post_reset_rsp0: got %b/%h/%b want %b/%h/%b", a_rsp_valid, a_rsp_data, a_rsp_error, e.idx, e.data, e.err);
        end
    endtask

    task automatic test_fixed_priority;
        int   t_prev;
        exp_t e;
        @(posedge clk);
        #1;
        b_req_addr = {22'h000302, 22'h000301, 22'h000300};
        b_req_write = 3'b000;
        b_req_valid = 3'b101;
        t_prev = 0;
        for (int g = 0; g < 10; g++) begin
            wait_b_ready(10);
            n_cmp++;
            if (b_req_ready !== 3'b001) begin
                n_bad++; $display("FAIL fixed_grant%0d: got %b want 001", g, b_req_ready);
            end
            t_prev = cyc;
            exp_q.push_back({3'b001, 16'h00B0, 1'b0});
            if (g == 9) begin
                @(posedge clk);
                #1;
                b_req_valid = 3'b100;
            end
            wait_b_rsp(10);
            e = exp_q.pop_front();
            n_cmp++;
            if ({b_rsp_valid, b_rsp_data, b_rsp_error} !== {e.idx, e.data, e.err}) begin
                n_bad++;
                $display("FAIL fixed_rsp%0d: got %b/%h/%b want %b/%h/%b", g, b_rsp_valid, b_rsp_data, b_rsp_error, e.idx, e.data, e.err);
            end
        end
        wait_b_ready(10);
        n_cmp++;
        if (b_req_ready !== 3'b100 || cyc - t_prev != 4) begin
            n_bad++; $display("FAIL fixed_grant2: got %b after %0d want 100 after 4", b_req_ready, cyc - t_prev);
        end
        exp_q.push_back({3'b100, 16'h00B0, 1'b0});
        @(posedge clk);
        #1;
        b_req_valid = 3'b000;
        wait_b_rsp(10);
        e = exp_q.pop_front();
        n_cmp++;
        if ({b_rsp_valid, b_rsp_data, b_rsp_error} !== {e.idx, e.data, e.err}) begin
            n_bad++;
            $display("FAIL fixed_rsp2: got %b/%h/%b want %b/%h/%b", b_rsp_valid, b_rsp_data, b_rsp_error, e.idx, e.data, e.err);
        end
    endtask

    initial begin
        cyc = 0; n_cmp = 0; n_bad = 0;
        test_reset();
        test_single_read();
        test_rr_fairness();
        test_timeout();
        test_ack_final();
        test_reset_wait();
        test_fixed_priority();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cram_access_arbiter.md
Name: cram_access_arbiter

Overview:
- Shares one cellular-RAM access port (cram0/cram1 style) between NUM_REQ requesters, e.g. the bridge ROM loader, the hiscore/dataslot engine and the core CPU fetch path.
- Requesters see a simple valid/ready command channel and a one-cycle response pulse.
- The memory side sees a strictly serialised stream with one transaction in flight at a time.
- Sits between the bridge leaves / core logic and the CRAM controller; runs entirely in one clock domain.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- ADDR_WIDTH, 22, word address width.
- DATA_WIDTH, 16, data word width.
- RR_MODE, 1, 1 = round-robin arbitration; 0 = fixed priority (index 0 highest).
- TIMEOUT_CYCLES, 255, maximum cycles spent waiting for mem_ack before aborting (≥4).

Ports:
- clk  in  1  sole clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_write  in  NUM_REQ  per-requester 1 = write, 0 = read.
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- req_ready  out  NUM_REQ  one-hot accept pulse.
- rsp_valid  out  NUM_REQ  one-hot completion pulse.
- rsp_error  out  1  qualifies rsp_valid; 1 = timed out.
- rsp_data  out  DATA_WIDTH  read data; valid with rsp_valid.
- mem_req  out  1  one-cycle command strobe to the CRAM controller.
- mem_write  out  1  command direction.
- mem_addr  out  ADDR_WIDTH  command address.
- mem_wdata  out  DATA_WIDTH  command write data.
- mem_ack  in  1  one-cycle completion from the CRAM controller.
- mem_rdata  in  DATA_WIDTH  read data; valid with mem_ack.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high.
- Reset state: state=IDLE, all outputs 0, last_grant=NUM_REQ-1 (so requester 0 wins the first RR decision), timeout counter 0.
- Requester rule: once req_valid[i] is raised, it stays high with req_write/addr/wdata stable until the cycle req_ready[i]=1. Dropping it earlier is illegal and not checked.
- Arbitration, done only in IDLE:
  - RR_MODE=1: search from (last_grant+1) mod NUM_REQ upward with wrap-around; the first valid requester wins.
  - RR_MODE=0: the lowest valid index wins.
- State IDLE:
  - If any req_valid is set, req_ready[g] is asserted combinationally in that same cycle for the winner g only.
  - On that edge: latch write/addr/wdata and g; update last_grant=g; go to ISSUE.
  - If no requester is valid, stay in IDLE.
- State ISSUE:
  - mem_req=1 for exactly this cycle, with the latched command on mem_write/mem_addr/mem_wdata.
  - Clear the timeout counter; go to WAIT.
- State WAIT: mem_req=0; mem_write/addr/wdata hold the latched values.
  - mem_ack=1: register mem_rdata (reads) or 0 (writes) into rsp_data; rsp_error=0; go to RESP.
  - Else, counter==TIMEOUT_CYCLES-1: rsp_data=0, rsp_error=1, go to RESP.
  - Else: increment the counter.
  - mem_ack wins if it coincides with the final timeout cycle.
- State RESP:
  - rsp_valid[g]=1 for exactly this cycle; rsp_data and rsp_error hold their values until the next RESP.
  - Go to IDLE.
- Latency and throughput:
  - Accept at cycle T, mem_req at T+1, earliest mem_ack at T+2, rsp_valid at T+3.
  - Next accept no earlier than T+4, so at most one transaction per 4 cycles.
- Timing constraints:
  - mem_ack outside WAIT (including one arriving after a timeout) is ignored.
  - mem_ack is not accepted in the ISSUE cycle.
- Simultaneous events:
  - A requester raising valid in RESP is first seen in the following IDLE cycle.
  - All requesters valid: each is served exactly once per NUM_REQ grants in RR mode.
  - Fixed mode may starve higher indices; this is by design.
- Reset mid-operation:
  - Any in-flight transaction is abandoned with no rsp_valid issued.
  - mem_req drops in the reset cycle; last_grant returns to NUM_REQ-1.

Test Plan:
- Single read: req_valid=3'b001, addr=0x00123, controller acks 2 cycles after mem_req with 0xBEEF -> req_ready[0] at T, mem_req at T+1 with mem_addr=0x00123 and mem_write=0, rsp_valid=3'b001 with rsp_data=0xBEEF and rsp_error=0 at T+4.
- RR fairness: all three requesters hold valid continuously, 0-wait acks -> grant order 0,1,2,0,1,2; each rsp_valid lands on the matching index; accepts spaced exactly 4 cycles apart.
- Fixed priority (RR_MODE=0): requesters 0 and 2 always valid -> requester 2 is never granted over 10 transactions; after 0 drops valid, 2 is granted at the next IDLE.
- Timeout: TIMEOUT_CYCLES=8, write from requester 1, no mem_ack -> rsp_valid=3'b010 with rsp_error=1 and rsp_data=0 at T+10; a late mem_ack at T+12 is ignored and busy=0.
- Ack on final timeout cycle: mem_ack with 0x1234 asserted on the 8th WAIT cycle -> rsp_error=0, rsp_data=0x1234.
- Reset in WAIT: assert reset for 1 cycle after mem_req -> all outputs 0 next cycle, no rsp_valid; subsequent request from requester 2 alone is granted normally, and when requesters 0 and 2 are both valid requester 0 wins.
